// File: rtl/claa_seq_arbiter_if.sv
// Handshake bundle between two add requesters, the shared nibble-serial
// adder and a single result consumer.
//   req0_* / req1_* : valid/ready request channels carrying a, b, cin
//   res_*           : valid/ready result channel carrying sum, cout, id
// The slave modport is the arbiter's view; the master modport is the
// client/consumer view.
interface claa_seq_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        input  res_ready,
        output res_valid, res_sum, res_cout, res_id
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        output res_ready,
        input  res_valid, res_sum, res_cout, res_id
    );
endinterface

// File: rtl/claa_seq_arbiter.sv
// Two-requester controller time-sharing one 4-bit carry look-ahead adder.
// A WIDTH-bit addition is done one nibble per clock, the carry chained
// through a register. A round-robin pointer picks between requesters.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : claa_seq_arbiter_if.slave (request channels 0/1, result channel)
// Also contains CLAA, the 4-bit carry look-ahead adder cell (s, cout, a, b, cin).

module CLAA (
    output logic [3:0] s,
    output logic       cout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Every carry is expanded directly from g/p and cin, no rippling
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign s    = p_s ^ c_s[3:0];
    assign cout = c_s[4];
endmodule

module claa_seq_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    claa_seq_arbiter_if.slave    bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_r;
    logic             id_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;

    logic             grant_s;
    logic             accept_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic             sel_cin_s;
    logic [3:0]       nib_sum_s;
    logic             nib_cout_s;

    CLAA u_claa (
        .s    (nib_sum_s),
        .cout (nib_cout_s),
        .a    (a_r[3:0]),
        .b    (b_r[3:0]),
        .cin  (carry_r)
    );

    // Round-robin pick: a lone valid wins, a tie goes to the requester not
    // served last, and with no valid the non-last requester is offered ready
    always_comb begin
        grant_s = ~last_r;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_r;
        end else if (bus.req0_valid) begin
            grant_s = 1'b0;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = ~last_r;
        end
    end

    // Payload of the granted requester
    always_comb begin
        sel_a_s   = bus.req0_a;
        sel_b_s   = bus.req0_b;
        sel_cin_s = bus.req0_cin;
        if (grant_s) begin
            sel_a_s   = bus.req1_a;
            sel_b_s   = bus.req1_b;
            sel_cin_s = bus.req1_cin;
        end else begin
            sel_a_s   = bus.req0_a;
            sel_b_s   = bus.req0_b;
            sel_cin_s = bus.req0_cin;
        end
    end

    assign accept_s = (state_r == IDLE) && !rst
                    && (grant_s ? bus.req1_valid : bus.req0_valid);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_NIB) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs; readies are held low while reset is asserted
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.res_valid  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rst) begin
                    bus.req0_ready = ~grant_s;
                    bus.req1_ready = grant_s;
                end else begin
                    bus.req0_ready = 1'b0;
                    bus.req1_ready = 1'b0;
                end
            end
            DONE:    bus.res_valid = 1'b1;
            default: bus.res_valid = 1'b0;
        endcase
    end

    assign bus.res_sum  = sum_r;
    assign bus.res_cout = carry_r;
    assign bus.res_id   = id_r;

    // Datapath: load on accept, one nibble per RUN cycle, hold in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r  <= 1'b1;
            id_r    <= 1'b0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        carry_r <= sel_cin_s;
                        id_r    <= grant_s;
                        last_r  <= grant_s;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r[{cnt_r, 2'b00} +: 4] <= nib_sum_s;
                    carry_r <= nib_cout_s;
                    a_r     <= a_r >> 3'd4;
                    b_r     <= b_r >> 3'd4;
                    // Stop at the last nibble so the counter never wraps
                    if (cnt_r != LAST_NIB) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_claa_seq_arbiter.sv
// Self-checking bench for claa_seq_arbiter (WIDTH = 16).
// A transaction-level model predicts readies, result timing and payload
// every cycle from the arbitration rules and a plain a + b + cin sum.
module tb_claa_seq_arbiter;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst;

    claa_seq_arbiter_if #(.WIDTH(WIDTH)) bus ();

    claa_seq_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Requester-side state
    bit          pend  [2];
    logic [15:0] op_a  [2];
    logic [15:0] op_b  [2];
    logic        op_cin[2];
    bit          acc   [2];

    // Model state
    bit          m_busy;
    bit          m_last;
    int          m_since;
    logic [15:0] m_sum;
    logic        m_cout;
    logic        m_id;
    int          n_results;
    logic [15:0] got_sum;
    logic        got_cout;
    logic        got_id;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply_drive();
        bus.req0_valid = pend[0];
        bus.req0_a     = op_a[0];
        bus.req0_b     = op_b[0];
        bus.req0_cin   = op_cin[0];
        bus.req1_valid = pend[1];
        bus.req1_a     = op_a[1];
        bus.req1_b     = op_b[1];
        bus.req1_cin   = op_cin[1];
    endtask

    task automatic present(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
        pend[i]   = 1'b1;
        op_a[i]   = a;
        op_b[i]   = b;
        op_cin[i] = c;
        apply_drive();
    endtask

    task automatic take(input int i);
        logic [16:0] full;
        full    = {1'b0, op_a[i]} + {1'b0, op_b[i]} + {16'd0, op_cin[i]};
        m_sum   = full[15:0];
        m_cout  = full[16];
        m_id    = (i == 1);
        m_last  = (i == 1);
        m_busy  = 1'b1;
        m_since = 0;
        acc[i]  = 1'b1;
    endtask

    // Called at the negedge: compare DUT against the model, then advance it
    task automatic monitor();
        bit er0, er1, ev, g;
        if (m_busy) m_since++;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        er0 = 1'b0;
        er1 = 1'b0;
        if (!m_busy) begin
            // Who should be offered the adder: a sole pending requester,
            // otherwise whoever was not served previously
            if (pend[0] && !pend[1])      g = 1'b0;
            else if (pend[1] && !pend[0]) g = 1'b1;
            else                          g = ~m_last;
            er0 = ~g;
            er1 = g;
        end
        check_eq("req0_ready", bus.req0_ready, er0);
        check_eq("req1_ready", bus.req1_ready, er1);
        ev = m_busy && (m_since > NIB);
        check_eq("res_valid", bus.res_valid, ev);
        if (ev) begin
            check_eq("res_sum", bus.res_sum, m_sum);
            check_eq("res_cout", bus.res_cout, m_cout);
            check_eq("res_id", bus.res_id, m_id);
            if (bus.res_ready) begin
                got_sum  = bus.res_sum;
                got_cout = bus.res_cout;
                got_id   = bus.res_id;
                m_busy   = 1'b0;
                n_results++;
            end
        end
        if (er0 && pend[0])      take(0);
        else if (er1 && pend[1]) take(1);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (acc[0]) pend[0] = 1'b0;
        if (acc[1]) pend[1] = 1'b0;
        apply_drive();
    endtask

    task automatic wait_results(input int target);
        int cyc;
        cyc = 0;
        while (n_results < target && cyc < 100) begin
            step();
            cyc++;
        end
        if (n_results < target) check_eq("result_timeout", n_results, target);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_last  = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        acc[0]  = 1'b0;
        acc[1]  = 1'b0;
        apply_drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int target,
                                 input logic [15:0] s, input logic c, input logic id);
        wait_results(target);
        check_eq({tag, "_sum"}, got_sum, s);
        check_eq({tag, "_cout"}, got_cout, c);
        check_eq({tag, "_id"}, got_id, id);
    endtask

    initial begin
        int cyc;
        int n0;
        rst = 1'b1;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            op_a[i] = 16'h0000; op_b[i] = 16'h0000; op_cin[i] = 1'b0;
        end
        n_results = 0;
        model_reset();
        // A valid during reset must still see ready low
        present(0, 16'h5555, 16'h5555, 1'b0);
        #2;
        check_eq("rst_req0_ready", bus.req0_ready, 1'b0);
        check_eq("rst_req1_ready", bus.req1_ready, 1'b0);
        check_eq("rst_res_valid", bus.res_valid, 1'b0);
        check_eq("rst_res_sum", bus.res_sum, 16'h0000);
        check_eq("rst_res_cout", bus.res_cout, 1'b0);
        check_eq("rst_res_id", bus.res_id, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Carry chain through several nibbles
        present(0, 16'h1234, 16'h0FFF, 1'b0);
        expect_result("chain", 1, 16'h2233, 1'b0, 1'b0);

        // Full wrap and carry-in propagation
        present(1, 16'hFFFF, 16'h0001, 1'b0);
        expect_result("wrap", 2, 16'h0000, 1'b1, 1'b1);
        present(0, 16'h7FFF, 16'h0000, 1'b1);
        expect_result("cin", 3, 16'h8000, 1'b0, 1'b0);

        // Simultaneous requests after reset: req0 first; req0 re-presents
        // at once so the next tie is decided in favour of req1
        do_reset();
        present(0, 16'h00FF, 16'h0001, 1'b0);
        present(1, 16'h0003, 16'h0005, 1'b0);
        step();
        present(0, 16'h0010, 16'h0020, 1'b0);
        expect_result("sim_a", 4, 16'h0100, 1'b0, 1'b0);
        expect_result("sim_b", 5, 16'h0008, 1'b0, 1'b1);
        expect_result("sim_c", 6, 16'h0030, 1'b0, 1'b0);

        // Backpressure: result held in DONE, no accept while both wait
        bus.res_ready = 1'b0;
        present(0, 16'h0F0F, 16'h0101, 1'b0);
        cyc = 0;
        while (!(m_busy && m_since > NIB) && cyc < 50) begin
            step();
            cyc++;
        end
        check_eq("bp_reach_done", (m_busy && m_since > NIB), 1'b1);
        present(0, 16'h1111, 16'h2222, 1'b0);
        present(1, 16'h3333, 16'h4444, 1'b1);
        repeat (5) step();
        bus.res_ready = 1'b1;
        expect_result("bp", 7, 16'h1010, 1'b0, 1'b0);
        expect_result("bp_next1", 8, 16'h7778, 1'b0, 1'b1);
        expect_result("bp_next0", 9, 16'h3333, 1'b0, 1'b0);

        // Reset during nibble 2
        present(0, 16'hABCD, 16'h1111, 1'b0);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_res_valid", bus.res_valid, 1'b0);
        check_eq("mid_res_sum", bus.res_sum, 16'h0000);
        check_eq("mid_res_cout", bus.res_cout, 1'b0);
        check_eq("mid_res_id", bus.res_id, 1'b0);
        check_eq("mid_req0_ready", bus.req0_ready, 1'b0);
        check_eq("mid_req1_ready", bus.req1_ready, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) step();
        present(0, 16'h0001, 16'h0001, 1'b0);
        present(1, 16'h0100, 16'h0200, 1'b0);
        expect_result("post_rst0", 10, 16'h0002, 1'b0, 1'b0);
        expect_result("post_rst1", 11, 16'h0300, 1'b0, 1'b1);

        // Randomized sweep with stalls and occasional withdrawn requests
        n0 = n_results;
        cyc = 0;
        while (n_results < n0 + 200 && cyc < 20000) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i]   = 1'b1;
                        op_a[i]   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                        op_b[i]   = 16'($urandom);
                        op_cin[i] = 1'($urandom);
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
            apply_drive();
            step();
            cyc++;
        end
        check_eq("sweep_count", (n_results >= n0 + 200), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
